// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
// mux_pkg : shared mode encodings and constant helpers for arb_mux_reg
// Revision : 1.0
// ============================================================================
package mux_pkg;

    localparam int MUX_MODE_SELECT = 0;
    localparam int MUX_MODE_RR     = 1;

    // Elaboration-time ceil(log2(n)); kept for flows without $clog2.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ============================================================================
// rr_picker : combinational round-robin search starting after 'last'
// Revision : 1.0
// ============================================================================
module rr_picker
    import mux_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int SEL_W  = clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [SEL_W-1:0]  last,
    output logic [SEL_W-1:0]  gnt_idx,
    output logic              gnt_any
);

    logic [SEL_W-1:0] w_idx;

    // Offsets 1..NUM_IN visit every channel once, ending back at 'last'.
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_IN; k++) begin
            w_idx = SEL_W'((32'(last) + 32'(k)) % 32'(NUM_IN));
            if (!gnt_any && req[w_idx]) begin
                gnt_any = 1'b1;
                gnt_idx = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/arb_mux_reg.sv
`default_nettype none
// ============================================================================
// arb_mux_reg : N-input registered mux with valid/ready, select or round-robin
// Revision : 1.0
// ============================================================================
module arb_mux_reg
    import mux_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = clog2(NUM_IN),
    parameter int MODE   = MUX_MODE_SELECT
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_src
);

    logic [WIDTH-1:0] out_data_q;
    logic [WIDTH-1:0] out_data_d;
    logic [SEL_W-1:0] out_src_q;
    logic [SEL_W-1:0] out_src_d;
    logic             out_valid_q;
    logic             out_valid_d;

    logic             w_load_en;
    logic             w_xfer;
    logic [SEL_W-1:0] w_gnt_idx;
    logic             w_gnt_valid;
    logic [WIDTH-1:0] w_chan [NUM_IN];

    for (genvar i = 0; i < NUM_IN; i++) begin : g_unpack
        assign w_chan[i] = in_data[i*WIDTH +: WIDTH];
    end

    if (MODE == MUX_MODE_RR) begin : g_rr
        logic [SEL_W-1:0] rr_last_q;
        logic [SEL_W-1:0] rr_last_d;
        logic             w_unused_sel;

        assign w_unused_sel = ^sel;

        rr_picker #(
            .NUM_IN (NUM_IN),
            .SEL_W  (SEL_W)
        ) u_picker (
            .req     (in_valid),
            .last    (rr_last_q),
            .gnt_idx (w_gnt_idx),
            .gnt_any (w_gnt_valid)
        );

        // A grant that is not taken (stall) must not move the pointer.
        assign rr_last_d = w_xfer ? w_gnt_idx : rr_last_q;

        always_ff @(posedge Clk) begin
            if (Rst) begin
                rr_last_q <= SEL_W'(NUM_IN - 1);
            end else begin
                rr_last_q <= rr_last_d;
            end
        end
    end else begin : g_sel
        // Out-of-range selects fall back to channel 0 like the legacy muxes.
        assign w_gnt_idx   = (32'(sel) < 32'(NUM_IN)) ? sel : '0;
        assign w_gnt_valid = 1'b1;
    end

    assign w_load_en = !out_valid_q || out_ready;
    assign in_ready  = (!Rst && w_load_en && w_gnt_valid) ? (NUM_IN'(1) << w_gnt_idx) : '0;
    assign w_xfer    = |(in_valid & in_ready);

    always_comb begin
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_valid_d = out_valid_q;
        if (w_xfer) begin
            out_data_d  = w_chan[w_gnt_idx];
            out_src_d   = w_gnt_idx;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_arb_mux_reg.sv
`default_nettype none
// ============================================================================
// tb_arb_mux_reg : scoreboard bench for select, round-robin and 3-input DUTs
// Revision : 1.0
// ============================================================================
module tb_arb_mux_reg;

    localparam logic [31:0] DA = 32'hAAAA0000;
    localparam logic [31:0] DB = 32'hBBBB0001;
    localparam logic [31:0] DC = 32'hCCCC0002;
    localparam logic [31:0] DD = 32'hDDDD0003;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  s;
    } exp_t;

    logic        Clk;
    logic        Rst;

    logic [127:0] s_data;
    logic [3:0]   s_valid, s_ready;
    logic [1:0]   s_sel, s_osrc;
    logic [31:0]  s_odata;
    logic         s_ovalid, s_oready;

    logic [127:0] r_data;
    logic [3:0]   r_valid, r_ready;
    logic [1:0]   r_sel, r_osrc;
    logic [31:0]  r_odata;
    logic         r_ovalid, r_oready;

    logic [23:0]  t_data;
    logic [2:0]   t_valid, t_ready;
    logic [1:0]   t_sel, t_osrc;
    logic [7:0]   t_odata;
    logic         t_ovalid, t_oready;

    exp_t        sb_q[$];
    exp_t        e;
    logic [31:0] chan [4];
    int          n_checks;
    int          n_errors;

    arb_mux_reg #(.WIDTH(32), .NUM_IN(4), .MODE(0)) dut_sel (
        .Clk(Clk), .Rst(Rst), .in_data(s_data), .in_valid(s_valid), .in_ready(s_ready),
        .sel(s_sel), .out_data(s_odata), .out_valid(s_ovalid), .out_ready(s_oready), .out_src(s_osrc)
    );

    arb_mux_reg #(.WIDTH(32), .NUM_IN(4), .MODE(1)) dut_rr (
        .Clk(Clk), .Rst(Rst), .in_data(r_data), .in_valid(r_valid), .in_ready(r_ready),
        .sel(r_sel), .out_data(r_odata), .out_valid(r_ovalid), .out_ready(r_oready), .out_src(r_osrc)
    );

    arb_mux_reg #(.WIDTH(8), .NUM_IN(3), .MODE(0)) dut_three (
        .Clk(Clk), .Rst(Rst), .in_data(t_data), .in_valid(t_valid), .in_ready(t_ready),
        .sel(t_sel), .out_data(t_odata), .out_valid(t_ovalid), .out_ready(t_oready), .out_src(t_osrc)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        s_valid = 4'hF; r_valid = 4'hF; t_valid = 3'h7;
        s_oready = 1'b1; r_oready = 1'b1; t_oready = 1'b1;
        s_sel = 2'd2; r_sel = 2'd0; t_sel = 2'd0;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++;
            if (s_ready !== 4'h0 || r_ready !== 4'h0 || t_ready !== 3'h0) begin
                n_errors++;
                $display("FAIL reset_ready: got sel=%b rr=%b three=%b, want all zero", s_ready, r_ready, t_ready);
            end
            tick();
            n_checks++;
            if ({s_ovalid, s_odata, s_osrc} !== 35'd0 || {r_ovalid, r_odata, r_osrc} !== 35'd0) begin
                n_errors++;
                $display("FAIL reset_out: got sel v=%b d=%h s=%0d rr v=%b d=%h s=%0d, want all zero",
                         s_ovalid, s_odata, s_osrc, r_ovalid, r_odata, r_osrc);
            end
            n_checks++;
            if ({t_ovalid, t_odata, t_osrc} !== 11'd0) begin
                n_errors++;
                $display("FAIL reset_out3: got v=%b d=%h s=%0d, want all zero", t_ovalid, t_odata, t_osrc);
            end
        end
        Rst = 1'b0;
        s_valid = 4'h0; r_valid = 4'h0; t_valid = 3'h0;
    endtask

    task automatic test_select();
        s_valid = 4'hF; s_sel = 2'd2; s_oready = 1'b1;
        #1;
        n_checks++;
        if (s_ready !== 4'b0100) begin
            n_errors++;
            $display("FAIL select_ready: got %b, want 0100", s_ready);
        end
        sb_q.push_back({DC, 2'd2});
        tick();
        n_checks++;
        e = sb_q.pop_front();
        if (s_ovalid !== 1'b1 || s_odata !== e.d || s_osrc !== e.s) begin
            n_errors++;
            $display("FAIL select_out: got v=%b d=%h s=%0d, want v=1 d=%h s=%0d", s_ovalid, s_odata, s_osrc, e.d, e.s);
        end
    endtask

    task automatic test_backpressure();
        s_oready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) s_sel = 2'd1;
            #1;
            n_checks++;
            if (s_ready !== 4'h0) begin
                n_errors++;
                $display("FAIL bp_ready: cycle %0d got %b, want 0000", c, s_ready);
            end
            tick();
            n_checks++;
            if (s_ovalid !== 1'b1 || s_odata !== DC || s_osrc !== 2'd2) begin
                n_errors++;
                $display("FAIL bp_hold: cycle %0d got v=%b d=%h s=%0d, want v=1 d=%h s=2", c, s_ovalid, s_odata, s_osrc, DC);
            end
        end
        s_oready = 1'b1;
        #1;
        n_checks++;
        if (s_ready !== 4'b0010) begin
            n_errors++;
            $display("FAIL bp_release_ready: got %b, want 0010", s_ready);
        end
        sb_q.push_back({DB, 2'd1});
        tick();
        n_checks++;
        e = sb_q.pop_front();
        if (s_ovalid !== 1'b1 || s_odata !== e.d || s_osrc !== e.s) begin
            n_errors++;
            $display("FAIL bp_release_out: got v=%b d=%h s=%0d, want v=1 d=%h s=%0d", s_ovalid, s_odata, s_osrc, e.d, e.s);
        end
        s_valid = 4'h0;
        #1;
        n_checks++;
        if (s_ready !== 4'b0010) begin
            n_errors++;
            $display("FAIL drain_ready: got %b, want 0010", s_ready);
        end
        tick();
        n_checks++;
        if (s_ovalid !== 1'b0 || s_odata !== DB || s_osrc !== 2'd1) begin
            n_errors++;
            $display("FAIL drain_out: got v=%b d=%h s=%0d, want v=0 d=%h s=1", s_ovalid, s_odata, s_osrc, DB);
        end
    endtask

    task automatic test_select_oob();
        logic [1:0] sels [2];
        logic [2:0] rdys [2];
        logic [7:0] dats [2];
        sels[0] = 2'd3; rdys[0] = 3'b001; dats[0] = 8'h11;
        sels[1] = 2'd2; rdys[1] = 3'b100; dats[1] = 8'h33;
        t_data = {8'h33, 8'h22, 8'h11};
        t_valid = 3'h7; t_oready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            t_sel = sels[c];
            #1;
            n_checks++;
            if (t_ready !== rdys[c]) begin
                n_errors++;
                $display("FAIL oob_ready: sel=%0d got %b, want %b", sels[c], t_ready, rdys[c]);
            end
            sb_q.push_back({24'd0, dats[c], (sels[c] == 2'd3) ? 2'd0 : sels[c]});
            tick();
            n_checks++;
            e = sb_q.pop_front();
            if (t_ovalid !== 1'b1 || {24'd0, t_odata} !== e.d || t_osrc !== e.s) begin
                n_errors++;
                $display("FAIL oob_out: got v=%b d=%h s=%0d, want v=1 d=%h s=%0d", t_ovalid, t_odata, t_osrc, e.d, e.s);
            end
        end
        t_valid = 3'h0;
    endtask

    task automatic test_rr_all();
        int srcs [6];
        srcs = '{0, 1, 2, 3, 0, 1};
        r_valid = 4'hF; r_oready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            n_checks++;
            if (r_ready !== (4'b0001 << srcs[c])) begin
                n_errors++;
                $display("FAIL rr_all_ready: cycle %0d got %b, want grant %0d", c, r_ready, srcs[c]);
            end
            sb_q.push_back({chan[srcs[c]], 2'(srcs[c])});
            tick();
            n_checks++;
            e = sb_q.pop_front();
            if (r_ovalid !== 1'b1 || r_odata !== e.d || r_osrc !== e.s) begin
                n_errors++;
                $display("FAIL rr_all_out: cycle %0d got v=%b d=%h s=%0d, want v=1 d=%h s=%0d",
                         c, r_ovalid, r_odata, r_osrc, e.d, e.s);
            end
        end
    endtask

    task automatic test_rr_sparse_stall();
        logic       ordy [4];
        logic [3:0] erdy [4];
        int         esrc [4];
        ordy = '{1'b1, 1'b0, 1'b1, 1'b1};
        erdy = '{4'b0010, 4'b0000, 4'b1000, 4'b0010};
        esrc = '{1, 1, 3, 1};
        Rst = 1'b1; r_valid = 4'h0;
        tick();
        Rst = 1'b0;
        r_valid = 4'b1010;
        for (int c = 0; c < 4; c++) begin
            r_oready = ordy[c];
            #1;
            n_checks++;
            if (r_ready !== erdy[c]) begin
                n_errors++;
                $display("FAIL rr_sparse_ready: cycle %0d got %b, want %b", c, r_ready, erdy[c]);
            end
            if (erdy[c] != 4'h0) sb_q.push_back({chan[esrc[c]], 2'(esrc[c])});
            tick();
            n_checks++;
            if (erdy[c] == 4'h0) begin
                if (r_ovalid !== 1'b1 || r_odata !== DB || r_osrc !== 2'd1) begin
                    n_errors++;
                    $display("FAIL rr_stall_hold: got v=%b d=%h s=%0d, want v=1 d=%h s=1", r_ovalid, r_odata, r_osrc, DB);
                end
            end else begin
                e = sb_q.pop_front();
                if (r_ovalid !== 1'b1 || r_odata !== e.d || r_osrc !== e.s) begin
                    n_errors++;
                    $display("FAIL rr_sparse_out: cycle %0d got v=%b d=%h s=%0d, want v=1 d=%h s=%0d",
                             c, r_ovalid, r_odata, r_osrc, e.d, e.s);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        r_valid = 4'hF; r_oready = 1'b1;
        #1;
        n_checks++;
        if (r_ready !== 4'b0100) begin
            n_errors++;
            $display("FAIL mid_pre_ready: got %b, want 0100", r_ready);
        end
        sb_q.push_back({DC, 2'd2});
        tick();
        n_checks++;
        e = sb_q.pop_front();
        if (r_ovalid !== 1'b1 || r_odata !== e.d || r_osrc !== e.s) begin
            n_errors++;
            $display("FAIL mid_pre_out: got v=%b d=%h s=%0d, want v=1 d=%h s=%0d", r_ovalid, r_odata, r_osrc, e.d, e.s);
        end
        Rst = 1'b1;
        #1;
        n_checks++;
        if (r_ready !== 4'h0) begin
            n_errors++;
            $display("FAIL mid_rst_ready: got %b, want 0000", r_ready);
        end
        tick();
        n_checks++;
        if ({r_ovalid, r_odata, r_osrc} !== 35'd0) begin
            n_errors++;
            $display("FAIL mid_rst_out: got v=%b d=%h s=%0d, want all zero", r_ovalid, r_odata, r_osrc);
        end
        Rst = 1'b0;
        #1;
        n_checks++;
        if (r_ready !== 4'b0001) begin
            n_errors++;
            $display("FAIL mid_post_ready: got %b, want 0001", r_ready);
        end
        sb_q.push_back({DA, 2'd0});
        tick();
        n_checks++;
        e = sb_q.pop_front();
        if (r_ovalid !== 1'b1 || r_odata !== e.d || r_osrc !== e.s) begin
            n_errors++;
            $display("FAIL mid_post_out: got v=%b d=%h s=%0d, want v=1 d=%h s=%0d", r_ovalid, r_odata, r_osrc, e.d, e.s);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        chan[0] = DA; chan[1] = DB; chan[2] = DC; chan[3] = DD;
        s_data = {DD, DC, DB, DA};
        r_data = {DD, DC, DB, DA};
        t_data = 24'd0;
        test_reset();
        test_select();
        test_backpressure();
        test_select_oob();
        test_rr_all();
        test_rr_sparse_stall();
        test_reset_mid();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
